pong_link_rx: RTL and testbench
===============================

# pong_link_rx

Receive end of the single-wire open-drain handoff link between the two ping-pong boards. Samples the shared `Dinout` line, filters glitches, and classifies each peer low pulse by width: short means ball handoff, long means peer missed (point to this board). After each valid frame it drives an acknowledge low pulse back on the same wire. It sits between the board pin and the game FSM, which consumes `handoff` and `miss`.

## Interface
- `MIN_LOW`, 16: shortest accepted low pulse, in cycles. Shorter pulses are glitches.
- `HIT_MAX`, 50000: widest low pulse classified as HANDOFF, in cycles.
- `MISS_MAX`, 200000: widest low pulse classified as MISS. Wider pulses are a link error.
- `ACK_GAP`, 100: line-high cycles required before the ack is driven.
- `ACK_LEN`, 1000: ack low-pulse width, in cycles.
- `SYNC_STAGES`, 2: input synchronizer depth.
- Constraint: MIN_LOW ≤ HIT_MAX < MISS_MAX.

- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `Dinout`  inout  1  open-drain link. The block drives 0 or z only and never drives 1.
- `en_rx`  in  1  receive enable, sampled only in IDLE.
- `handoff`  out  1  one-cycle pulse: peer handed the ball over.
- `miss`  out  1  one-cycle pulse: peer missed.
- `link_err`  out  1  level: line stuck low.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_cnt`  out  4  count of valid frames. Wraps 15→0.

## Operation
- Input path:
  - `Dinout` passes through SYNC_STAGES flops to produce `s_line`.
  - While the block is driving the ack (ACK state), the sampled value is forced to 1 so the block never sees its own drive.
- Low-width counter `cnt`:
  - Width is clog2(MISS_MAX+2).
  - Saturates at MISS_MAX+1.
- State machine:
  - IDLE:
    - Entered with `cnt`=0 and the line released.
    - If `en_rx`=1 and `s_line`=0: go to LOW_MEAS with `cnt`=1.
  - LOW_MEAS:
    - While `s_line`=0: `cnt`++.
    - When `cnt` reaches MISS_MAX+1: go to ERR.
    - On `s_line`=1:
      - `cnt` < MIN_LOW: glitch. Go to IDLE with no output.
      - MIN_LOW ≤ `cnt` ≤ HIT_MAX: pulse `handoff`, go to GAP.
      - HIT_MAX < `cnt` ≤ MISS_MAX: pulse `miss`, go to GAP.
      - Both valid outcomes also increment `frame_cnt`.
  - GAP:
    - Count ACK_GAP consecutive `s_line`=1 cycles, then go to ACK.
    - If `s_line`=0 during GAP (collision or new frame): skip the ack and go to LOW_MEAS with `cnt`=1.
  - ACK:
    - Drive `Dinout`=0 for exactly ACK_LEN cycles, then release (z) and go to RECOVER.
  - RECOVER:
    - Wait SYNC_STAGES+1 cycles so the synchronizer flushes.
    - Then wait for `s_line`=1 and go to IDLE.
    - If `s_line` stays low for MISS_MAX cycles: go to ERR.
  - ERR:
    - `link_err`=1.
    - Line released.
    - After `s_line`=1 for MIN_LOW consecutive cycles: clear `link_err` and go to IDLE.
- `en_rx` deasserted mid-frame has no effect. The current frame, including its ack, completes.
- `handoff` and `miss` are mutually exclusive and never both high.

## Timing
- Reset values:
  - `handoff`=0, `miss`=0, `link_err`=0, `busy`=0, `frame_cnt`=0.
  - `Dinout`=z.
  - Synchronizer flops=1.
  - State=IDLE.
- Reset asserted mid-ACK releases `Dinout` immediately (asynchronous path).
- Detection latency: `handoff` or `miss` goes high SYNC_STAGES+1 rising edges after the raw line rises, and stays high exactly 1 cycle.
- Width measurement: `cnt` equals the number of synchronized low samples, so pulse width is measured to ±1 cycle of the raw pulse.
- Ack timing:
  - The ack starts ACK_GAP+1 cycles after the `handoff`/`miss` pulse.
  - The ack lasts ACK_LEN cycles.
  - `busy` stays high through RECOVER.
- Stuck-low detection: `link_err` rises on the cycle `cnt` reaches MISS_MAX+1, with no `miss` pulse.
- Boundaries:
  - Width MIN_LOW-1 → nothing. Width MIN_LOW → handoff.
  - Width HIT_MAX → handoff. Width HIT_MAX+1 → miss.
  - Width MISS_MAX → miss. Width MISS_MAX+1 → err.
  - `frame_cnt` at 15 plus a valid frame → 0.

## Test plan
All scenarios use MIN_LOW=4, HIT_MAX=20, MISS_MAX=60, ACK_GAP=3, ACK_LEN=8, SYNC_STAGES=2.

- Reset with line high:
  - Stimulus: hold `rst`=0, then release.
  - Required: all outputs 0, `Dinout`=z, `busy`=0.
- Handoff:
  - Stimulus: drive a 10-cycle low pulse.
  - Required: one-cycle `handoff` 3 cycles after release, `frame_cnt`=1, then `Dinout` low for exactly 8 cycles starting 4 cycles after `handoff`, then `busy`=0.
- Width sweep:
  - Stimulus: pulses of width 3, 4, 20, 21, 60.
  - Required: none, handoff, handoff, miss, miss. `frame_cnt` ends at 4. No `link_err`.
- Stuck low:
  - Stimulus: hold the line low for 100 cycles, then release.
  - Required: `link_err`=1 at 61 synchronized low samples, no `miss`. `link_err` clears 4 cycles after `s_line` returns high.
- Collision and enable:
  - Collision: re-drive the line low 2 cycles into GAP after a handoff. Required: no ack, the new pulse is measured.
  - Enable: with `en_rx`=0 in IDLE, a 10-cycle pulse. Required: ignored.
- Wrap and reset mid-ack:
  - Wrap: 16 handoff frames. Required: `frame_cnt` returns to 0.
  - Reset mid-ack: assert `rst` during ACK. Required: `Dinout`=z the same cycle, all outputs reset.

Source files
------------

// File: rtl/pong_link_rx.sv
// pong_link_rx: receive end of the single-wire open-drain handoff link.
//
// Samples the shared line through a reset-to-high synchronizer and measures
// each peer low pulse. Pulses shorter than MIN_LOW are dropped as glitches.
// Widths up to HIT_MAX report a ball handoff. Widths up to MISS_MAX report a
// peer miss. A longer low is a stuck line. After every valid frame the block
// waits for a quiet gap and then pulls the line low for ACK_LEN cycles as an
// acknowledge.
//
// Ports:
//   clk        system clock, single domain
//   rst        asynchronous active-low reset
//   Dinout     open-drain link; this block only ever drives 0 or z
//   en_rx      receive enable, sampled only while idle
//   handoff    one-cycle pulse: peer handed the ball over
//   miss       one-cycle pulse: peer missed
//   link_err   level: line stuck low
//   busy       high whenever the receiver is not idle
//   frame_cnt  count of valid frames, wraps 15 -> 0
//   dbg_state  current receiver state encoding (observation only)
//
// Handshake: there is no valid/ready pair here. handoff and miss are
// single-cycle event strobes with no back-pressure; the consumer must take
// them in the cycle they are high. They are mutually exclusive.
module pong_link_rx #(
  parameter int MIN_LOW     = 16,
  parameter int HIT_MAX     = 50000,
  parameter int MISS_MAX    = 200000,
  parameter int ACK_GAP     = 100,
  parameter int ACK_LEN     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        Dinout,
  input  logic       en_rx,
  output logic       handoff,
  output logic       miss,
  output logic       link_err,
  output logic       busy,
  output logic [3:0] frame_cnt,
  output logic [2:0] dbg_state
);

  // Low-width counter: room for MISS_MAX+1 so a stuck line is distinguishable
  // from the widest legal miss pulse.
  localparam int CW   = $clog2(MISS_MAX + 2);
  // General-purpose counter for gap, ack, flush and error-recovery timing.
  localparam int G1   = (ACK_LEN > ACK_GAP) ? ACK_LEN : ACK_GAP;
  localparam int G2   = (MIN_LOW > SYNC_STAGES + 1) ? MIN_LOW : SYNC_STAGES + 1;
  localparam int GMAX = (G1 > G2) ? G1 : G2;
  localparam int GW   = $clog2(GMAX + 1);

  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_MIN     = CW'(MIN_LOW);
  localparam logic [CW-1:0] C_HIT     = CW'(HIT_MAX);
  localparam logic [CW-1:0] C_MISS    = CW'(MISS_MAX);
  localparam logic [CW-1:0] C_MISS_M1 = CW'(MISS_MAX - 1);
  localparam logic [CW-1:0] C_SAT     = CW'(MISS_MAX + 1);

  localparam logic [GW-1:0] G_GAP      = GW'(ACK_GAP);
  localparam logic [GW-1:0] G_ACK_LAST = GW'(ACK_LEN - 1);
  localparam logic [GW-1:0] G_MIN_LAST = GW'(MIN_LOW - 1);
  localparam logic [GW-1:0] G_FLUSH    = GW'(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOW     = 3'd1,
    S_GAP     = 3'd2,
    S_ACK     = 3'd3,
    S_RECOVER = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [GW-1:0]          gcnt, gcnt_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   drive_low;
  logic                   s_line;
  logic                   handoff_nxt, miss_nxt, err_nxt;
  logic [3:0]             frame_nxt;

  // Open-drain output: pull low during the ack, otherwise release.
  assign Dinout = drive_low ? 1'b0 : 1'bz;

  // Our own ack drive must not look like a peer pulse.
  assign s_line    = (state == S_ACK) ? 1'b1 : sync_q[SYNC_STAGES-1];
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gcnt_nxt    = gcnt;
    handoff_nxt = 1'b0;
    miss_nxt    = 1'b0;
    err_nxt     = link_err;
    frame_nxt   = frame_cnt;
    case (state)
      S_IDLE: begin
        cnt_nxt  = '0;
        gcnt_nxt = '0;
        if (en_rx && !s_line) begin
          state_nxt = S_LOW;
          cnt_nxt   = C_ONE;
        end
      end
      S_LOW: begin
        gcnt_nxt = '0;
        if (!s_line) begin
          if (cnt >= C_MISS) begin
            // One sample past the widest miss: stuck line, no miss strobe.
            cnt_nxt   = C_SAT;
            state_nxt = S_ERR;
            err_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (cnt < C_MIN) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          // cnt cannot exceed MISS_MAX here; wider lows were caught above.
          if (cnt <= C_HIT) handoff_nxt = 1'b1;
          else              miss_nxt    = 1'b1;
          frame_nxt = frame_cnt + 4'd1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (!s_line) begin
          // Peer started talking again: drop the ack and measure the new low.
          state_nxt = S_LOW;
          cnt_nxt   = C_ONE;
          gcnt_nxt  = '0;
        end else if (gcnt == G_GAP) begin
          state_nxt = S_ACK;
          gcnt_nxt  = '0;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end
      S_ACK: begin
        if (gcnt == G_ACK_LAST) begin
          state_nxt = S_RECOVER;
          gcnt_nxt  = '0;
          cnt_nxt   = '0;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end
      S_RECOVER: begin
        // First let our own low drain out of the synchronizer, then wait
        // for the line to read high.
        if (gcnt != G_FLUSH) begin
          gcnt_nxt = gcnt + 1'b1;
        end else if (s_line) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          gcnt_nxt  = '0;
        end else if (cnt == C_MISS_M1) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
          cnt_nxt   = cnt + 1'b1;
          gcnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_ERR: begin
        if (!s_line) begin
          gcnt_nxt = '0;
        end else if (gcnt == G_MIN_LAST) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b0;
          cnt_nxt   = '0;
          gcnt_nxt  = '0;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        gcnt_nxt  = '0;
        err_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gcnt      <= '0;
      handoff   <= 1'b0;
      miss      <= 1'b0;
      link_err  <= 1'b0;
      frame_cnt <= '0;
      drive_low <= 1'b0;
      sync_q    <= '1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gcnt      <= gcnt_nxt;
      handoff   <= handoff_nxt;
      miss      <= miss_nxt;
      link_err  <= err_nxt;
      frame_cnt <= frame_nxt;
      // Registered so the pin never glitches on state decode.
      drive_low <= (state_nxt == S_ACK);
      sync_q[0] <= Dinout;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

endmodule

// File: tb/tb_pong_link_rx.sv
`timescale 1ns/1ps
module tb_pong_link_rx;
  localparam int MIN_LOW     = 4;
  localparam int HIT_MAX     = 20;
  localparam int MISS_MAX    = 60;
  localparam int ACK_GAP     = 3;
  localparam int ACK_LEN     = 8;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_rx = 1'b1;
  logic       peer_low = 1'b0;
  wire        Dinout;
  logic       handoff, miss, link_err, busy;
  logic [3:0] frame_cnt;
  logic [2:0] dbg_state;

  // Peer side of the open-drain wire plus the board pull-up.
  assign Dinout = peer_low ? 1'b0 : 1'bz;
  pullup (Dinout);

  pong_link_rx #(
    .MIN_LOW(MIN_LOW), .HIT_MAX(HIT_MAX), .MISS_MAX(MISS_MAX),
    .ACK_GAP(ACK_GAP), .ACK_LEN(ACK_LEN), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .Dinout(Dinout), .en_rx(en_rx),
    .handoff(handoff), .miss(miss), .link_err(link_err), .busy(busy),
    .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int exp_frame = 0;
  logic [1:0] exp_q[$];  // expected frame kind per random frame

  int cyc, n_hand, n_miss, n_both, n_err_rise, ack_n, ack_first, evt_cyc, err_cyc, rel_cyc;
  bit err_prev, busy_seen;

  // Kind of a low pulse of width w: 0 none, 1 handoff, 2 miss, 3 link error.
  function automatic logic [1:0] expect_kind(input int w);
    if (w < MIN_LOW)  return 2'd0;
    if (w <= HIT_MAX) return 2'd1;
    if (w <= MISS_MAX) return 2'd2;
    return 2'd3;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    cyc = 0; n_hand = 0; n_miss = 0; n_both = 0; n_err_rise = 0;
    ack_n = 0; ack_first = -1; evt_cyc = -1; err_cyc = -1; rel_cyc = -1;
    err_prev = link_err; busy_seen = 1'b0;
  endtask

  // Advance one cycle and record what the DUT showed at the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (handoff) begin n_hand++; evt_cyc = cyc; end
    if (miss)    begin n_miss++; evt_cyc = cyc; end
    if (handoff && miss) n_both++;
    if (link_err && !err_prev) begin n_err_rise++; err_cyc = cyc; end
    err_prev = link_err;
    if (!peer_low && Dinout === 1'b0) begin
      ack_n++;
      if (ack_first < 0) ack_first = cyc;
    end
    if (busy) busy_seen = 1'b1;
  endtask

  task automatic send_pulse(input int w);
    peer_low = 1'b1;
    repeat (w) tick();
    peer_low = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic run_frame(input int w);
    clear_obs();
    send_pulse(w);
    repeat (30) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    peer_low = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_frame = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({handoff, miss, link_err, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags_in_reset: got %b expected 0000", {handoff, miss, link_err, busy});
    end
    checks++;
    if (Dinout !== 1'b1) begin
      errors++; $display("FAIL reset_line_released: got %b expected 1", Dinout);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    exp_frame = 0;
    checks++;
    if ({handoff, miss, link_err, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags_after: got %b expected 0000", {handoff, miss, link_err, busy});
    end
    checks++;
    if (frame_cnt !== 4'(exp_frame)) begin
      errors++; $display("FAIL reset_frame_cnt: got %0d expected %0d", frame_cnt, exp_frame);
    end
    checks++;
    if (Dinout !== 1'b1) begin
      errors++; $display("FAIL reset_line_after: got %b expected 1", Dinout);
    end
  endtask

  task automatic test_handoff();
    run_frame(10);
    exp_frame = (exp_frame + 1) % 16;
    checks++;
    if (n_hand !== 1 || n_miss !== 0) begin
      errors++; $display("FAIL handoff_pulses: got hand=%0d miss=%0d expected 1/0", n_hand, n_miss);
    end
    checks++;
    if (evt_cyc - rel_cyc !== SYNC_STAGES + 1) begin
      errors++; $display("FAIL handoff_latency: got %0d expected %0d", evt_cyc - rel_cyc, SYNC_STAGES + 1);
    end
    checks++;
    if (frame_cnt !== 4'(exp_frame)) begin
      errors++; $display("FAIL handoff_frame_cnt: got %0d expected %0d", frame_cnt, exp_frame);
    end
    checks++;
    if (ack_first - evt_cyc !== ACK_GAP + 1) begin
      errors++; $display("FAIL handoff_ack_start: got %0d expected %0d", ack_first - evt_cyc, ACK_GAP + 1);
    end
    checks++;
    if (ack_n !== ACK_LEN) begin
      errors++; $display("FAIL handoff_ack_len: got %0d expected %0d", ack_n, ACK_LEN);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL handoff_busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_width_sweep();
    int widths[5] = '{3, 4, 20, 21, 60};
    logic [1:0] k;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      k = expect_kind(widths[i]);
      run_frame(widths[i]);
      if (k == 2'd1 || k == 2'd2) exp_frame = (exp_frame + 1) % 16;
      checks++;
      if (n_hand !== int'(k == 2'd1) || n_miss !== int'(k == 2'd2)) begin
        errors++; $display("FAIL sweep_w%0d_kind: got hand=%0d miss=%0d expected kind %0d", widths[i], n_hand, n_miss, k);
      end
      checks++;
      if (ack_n !== ((k == 2'd1 || k == 2'd2) ? ACK_LEN : 0)) begin
        errors++; $display("FAIL sweep_w%0d_ack: got %0d cycles", widths[i], ack_n);
      end
      checks++;
      if (n_err_rise !== 0) begin
        errors++; $display("FAIL sweep_w%0d_err: got %0d rises expected 0", widths[i], n_err_rise);
      end
    end
    checks++;
    if (frame_cnt !== 4'(exp_frame) || exp_frame != 4) begin
      errors++; $display("FAIL sweep_frame_cnt: got %0d expected 4", frame_cnt);
    end
  endtask

  task automatic test_stuck_low();
    clear_obs();
    peer_low = 1'b1;
    repeat (MISS_MAX + SYNC_STAGES) tick();
    checks++;
    if (link_err !== 1'b0) begin
      errors++; $display("FAIL stuck_err_early: got %b expected 0 at %0d samples", link_err, MISS_MAX);
    end
    tick();
    checks++;
    if (link_err !== 1'b1) begin
      errors++; $display("FAIL stuck_err_rise: got %b expected 1 at %0d samples", link_err, MISS_MAX + 1);
    end
    repeat (100 - (MISS_MAX + SYNC_STAGES + 1)) tick();
    peer_low = 1'b0;
    repeat (SYNC_STAGES + MIN_LOW - 1) tick();
    checks++;
    if (link_err !== 1'b1) begin
      errors++; $display("FAIL stuck_err_hold: got %b expected 1", link_err);
    end
    tick();
    checks++;
    if (link_err !== 1'b0) begin
      errors++; $display("FAIL stuck_err_clear: got %b expected 0", link_err);
    end
    repeat (10) tick();
    checks++;
    if (n_miss !== 0 || n_hand !== 0 || ack_n !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL stuck_side_effects: got miss=%0d hand=%0d ack=%0d busy=%b expected 0/0/0/0", n_miss, n_hand, ack_n, busy);
    end
    checks++;
    if (frame_cnt !== 4'(exp_frame)) begin
      errors++; $display("FAIL stuck_frame_cnt: got %0d expected %0d", frame_cnt, exp_frame);
    end
  endtask

  task automatic test_collision();
    clear_obs();
    send_pulse(10);
    repeat (SYNC_STAGES + 1) tick();
    checks++;
    if (n_hand !== 1) begin
      errors++; $display("FAIL collision_first: got hand=%0d expected 1", n_hand);
    end
    tick();
    // Line goes low again while the receiver is waiting out the gap.
    send_pulse(30);
    repeat (30) tick();
    exp_frame = (exp_frame + 2) % 16;
    checks++;
    if (n_miss !== 1 || n_hand !== 1) begin
      errors++; $display("FAIL collision_second: got hand=%0d miss=%0d expected 1/1", n_hand, n_miss);
    end
    checks++;
    if (ack_n !== ACK_LEN) begin
      errors++; $display("FAIL collision_ack: got %0d cycles expected %0d", ack_n, ACK_LEN);
    end
    checks++;
    if (frame_cnt !== 4'(exp_frame)) begin
      errors++; $display("FAIL collision_frame_cnt: got %0d expected %0d", frame_cnt, exp_frame);
    end
  endtask

  task automatic test_enable();
    en_rx = 1'b0;
    run_frame(10);
    checks++;
    if (n_hand !== 0 || n_miss !== 0 || ack_n !== 0 || busy_seen !== 1'b0) begin
      errors++; $display("FAIL enable_off: got hand=%0d miss=%0d ack=%0d busy=%b expected none", n_hand, n_miss, ack_n, busy_seen);
    end
    // Dropping enable mid-frame must not abort the frame.
    en_rx = 1'b1;
    clear_obs();
    peer_low = 1'b1;
    repeat (5) tick();
    en_rx = 1'b0;
    repeat (5) tick();
    peer_low = 1'b0;
    repeat (30) tick();
    en_rx = 1'b1;
    exp_frame = (exp_frame + 1) % 16;
    checks++;
    if (n_hand !== 1 || ack_n !== ACK_LEN) begin
      errors++; $display("FAIL enable_mid_frame: got hand=%0d ack=%0d expected 1/%0d", n_hand, ack_n, ACK_LEN);
    end
    checks++;
    if (frame_cnt !== 4'(exp_frame)) begin
      errors++; $display("FAIL enable_frame_cnt: got %0d expected %0d", frame_cnt, exp_frame);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      run_frame(8);
      exp_frame = (exp_frame + 1) % 16;
      if (i == 14) begin
        checks++;
        if (frame_cnt !== 4'd15) begin
          errors++; $display("FAIL wrap_at_15: got %0d expected 15", frame_cnt);
        end
      end
    end
    checks++;
    if (frame_cnt !== 4'(exp_frame) || exp_frame != 0) begin
      errors++; $display("FAIL wrap_to_0: got %0d expected 0", frame_cnt);
    end
  endtask

  task automatic test_random();
    int w;
    logic [1:0] k;
    int both_total = 0;
    for (int i = 0; i < 12; i++) begin
      w = $urandom_range(1, 70);
      exp_q.push_back(expect_kind(w));
      run_frame(w);
      both_total += n_both;
      k = exp_q.pop_front();
      if (k == 2'd1 || k == 2'd2) exp_frame = (exp_frame + 1) % 16;
      checks++;
      if (n_hand !== int'(k == 2'd1) || n_miss !== int'(k == 2'd2) || n_err_rise !== int'(k == 2'd3)) begin
        errors++; $display("FAIL rand_w%0d_kind: got hand=%0d miss=%0d err=%0d expected kind %0d", w, n_hand, n_miss, n_err_rise, k);
      end
      checks++;
      if (ack_n !== ((k == 2'd1 || k == 2'd2) ? ACK_LEN : 0) || busy !== 1'b0 || link_err !== 1'b0) begin
        errors++; $display("FAIL rand_w%0d_after: got ack=%0d busy=%b err=%b", w, ack_n, busy, link_err);
      end
      checks++;
      if (frame_cnt !== 4'(exp_frame)) begin
        errors++; $display("FAIL rand_w%0d_frame_cnt: got %0d expected %0d", w, frame_cnt, exp_frame);
      end
    end
    checks++;
    if (both_total !== 0) begin
      errors++; $display("FAIL rand_exclusive: got %0d overlapping cycles expected 0", both_total);
    end
  endtask

  task automatic test_reset_mid_ack();
    clear_obs();
    send_pulse(10);
    repeat (10) tick();
    checks++;
    if (Dinout !== 1'b0) begin
      errors++; $display("FAIL midack_active: got %b expected 0", Dinout);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (Dinout !== 1'b1) begin
      errors++; $display("FAIL midack_release: got %b expected 1", Dinout);
    end
    checks++;
    if ({handoff, miss, link_err, busy} !== 4'b0000 || frame_cnt !== 4'd0) begin
      errors++; $display("FAIL midack_outputs: got flags=%b frame=%0d expected 0000/0", {handoff, miss, link_err, busy}, frame_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_frame = 0;
    clear_obs();
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || ack_n !== 0) begin
      errors++; $display("FAIL midack_after: got busy=%b ack=%0d expected 0/0", busy, ack_n);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_handoff();
    test_width_sweep();
    test_stuck_low();
    test_collision();
    test_enable();
    test_wrap();
    test_random();
    test_reset_mid_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
